// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared widths, instruction-length codes and the fetch FSM state type for
// the 6502 fetch unit, its bus interface and the opcode length decoder.
package fetch_unit_pkg;

  localparam int REG_WIDTH     = 8;   // data / opcode width
  localparam int ADDR_WIDTH    = 16;  // memory address width
  localparam int OPERAND_WIDTH = 16;  // {hi, lo} operand bytes

  // Instruction length in bytes (1..3); 0 is never produced.
  typedef logic [1:0] len_t;
  localparam len_t LEN_1 = 2'd1;
  localparam len_t LEN_2 = 2'd2;
  localparam len_t LEN_3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,     // after reset, waiting for the first pc_load
    ST_ISSUE,    // one-cycle read strobe for PC + byte_idx
    ST_WAIT,     // counting memory latency
    ST_CAPTURE,  // file the returned byte
    ST_PRESENT,  // instruction_ready held until instruction_done
    ST_GAP       // one idle cycle so ready shows a fresh rising edge
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the memory read port and the decoder handshake of the fetch unit.
//   mem_addr/mem_re     fetch -> memory   read address and one-cycle strobe
//   mem_rdata           memory -> fetch   read data, MEM_LATENCY cycles later
//   instruction_out     fetch -> decoder  opcode
//   operand             fetch -> decoder  {hi, lo}, unused bytes 0
//   addr_out            fetch -> decoder  address of the opcode byte
//   instruction_ready   fetch -> decoder  instruction valid, held until done
//   illegal             fetch -> decoder  opcode outside the supported set
//   instruction_done    decoder -> fetch  decoder finished the instruction
// modport master: the fetch unit; modport slave: memory + decoder side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic                     mem_re;
  logic [REG_WIDTH-1:0]     mem_rdata;
  logic [REG_WIDTH-1:0]     instruction_out;
  logic [OPERAND_WIDTH-1:0] operand;
  logic [ADDR_WIDTH-1:0]    addr_out;
  logic                     instruction_ready;
  logic                     illegal;
  logic                     instruction_done;

  modport master (
    output mem_addr, mem_re,
    input  mem_rdata,
    output instruction_out, operand, addr_out, instruction_ready, illegal,
    input  instruction_done
  );

  modport slave (
    input  mem_addr, mem_re,
    output mem_rdata,
    input  instruction_out, operand, addr_out, instruction_ready, illegal,
    output instruction_done
  );

endinterface

// File: rtl/fetch_unit_op_length.sv
// fetch_unit_op_length
// Combinational 6502 opcode (aaabbbcc) -> instruction length and illegal flag.
//   opcode   in   REG_WIDTH  opcode byte
//   len      out  2          instruction length in bytes (1..3)
//   illegal  out  1          set for cc=11 opcodes, which this core rejects
module fetch_unit_op_length
  import fetch_unit_pkg::*;
(
  input  logic [REG_WIDTH-1:0] opcode,
  output len_t                 len,
  output logic                 illegal
);

  logic [2:0] bbb;
  assign bbb = opcode[4:2];

  always_comb begin
    len     = LEN_2;
    illegal = 1'b0;
    case (opcode[1:0])
      2'b01: begin
        // ALU group: abs, abs,Y and abs,X carry a 16-bit address.
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = LEN_3;
      end
      2'b11: begin
        len     = LEN_1;
        illegal = 1'b1;
      end
      default: begin
        case (bbb)
          3'b000: begin
            // BRK/RTI/RTS are implied; JSR takes an absolute address.
            if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) len = LEN_1;
            else if (opcode == 8'h20)                                  len = LEN_3;
            else                                                       len = LEN_2;
          end
          3'b010, 3'b110: len = LEN_1;
          3'b011, 3'b111: len = LEN_3;
          default:        len = LEN_2;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// 6502 instruction fetch sequencer: reads the opcode at PC and its 0-2
// operand bytes, presents {opcode, operand, addr} to the decoder and holds it
// until instruction_done, then advances PC and fetches the next instruction.
//   clk            in   single clock, posedge
//   reset          in   synchronous, active-high; wins over everything
//   pc_load        in   load PC and restart fetching; aborts a fetch in flight
//   pc_load_value  in   new PC
//   pc             out  PC of the current / next sequential instruction
//   bus            fetch_unit_if.master: memory read port + decoder handshake
// MEM_LATENCY: cycles from mem_re to valid mem_rdata, 1..4.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [ADDR_WIDTH-1:0] pc,
  fetch_unit_if.master          bus
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

  fetch_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    pc_reg;
  logic [1:0]               byte_idx_reg;
  logic [1:0]               lat_cnt_reg;
  logic [REG_WIDTH-1:0]     byte_reg;
  logic [REG_WIDTH-1:0]     instr_reg;
  logic [OPERAND_WIDTH-1:0] operand_reg;
  logic [ADDR_WIDTH-1:0]    addr_reg;
  len_t                     len_reg;
  logic                     illegal_reg;

  logic mem_re;
  logic ready;
  len_t op_len;
  logic op_illegal;
  len_t total_len;
  logic last_byte;

  // Decodes the byte just captured; only used while byte_idx is 0.
  fetch_unit_op_length u_op_length (
    .opcode  (byte_reg),
    .len     (op_len),
    .illegal (op_illegal)
  );

  // While capturing the opcode the length comes straight from the decoder,
  // afterwards from the latched copy.
  assign total_len = (byte_idx_reg == 2'd0) ? op_len : len_reg;
  assign last_byte = (byte_idx_reg + 2'd1) == total_len;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_re     = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      ST_IDLE:    state_next = ST_IDLE;
      ST_ISSUE: begin
        mem_re     = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT:    if (lat_cnt_reg == LAT_LAST) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = last_byte ? ST_PRESENT : ST_ISSUE;
      ST_PRESENT: begin
        ready = 1'b1;
        if (bus.instruction_done) state_next = ST_GAP;
      end
      ST_GAP:     state_next = ST_ISSUE;
      default:    state_next = ST_IDLE;
    endcase
    // A load restarts fetching from any state, including a done handshake.
    if (pc_load) state_next = ST_ISSUE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= '0;
      byte_idx_reg <= '0;
      lat_cnt_reg  <= '0;
      byte_reg     <= '0;
      instr_reg    <= '0;
      operand_reg  <= '0;
      addr_reg     <= '0;
      len_reg      <= LEN_1;
      illegal_reg  <= 1'b0;
    end else if (pc_load) begin
      pc_reg       <= pc_load_value;
      byte_idx_reg <= '0;
      lat_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        ST_ISSUE: lat_cnt_reg <= '0;
        ST_WAIT: begin
          if (lat_cnt_reg == LAT_LAST) byte_reg    <= bus.mem_rdata;
          else                         lat_cnt_reg <= lat_cnt_reg + 2'd1;
        end
        ST_CAPTURE: begin
          if (byte_idx_reg == 2'd0) begin
            instr_reg   <= byte_reg;
            len_reg     <= op_len;
            illegal_reg <= op_illegal;
            addr_reg    <= pc_reg;
            operand_reg <= '0;
          end else if (byte_idx_reg == 2'd1) begin
            operand_reg <= {8'h00, byte_reg};
          end else begin
            operand_reg[15:8] <= byte_reg;
          end
          byte_idx_reg <= last_byte ? 2'd0 : byte_idx_reg + 2'd1;
        end
        ST_PRESENT: begin
          if (bus.instruction_done) pc_reg <= pc_reg + ADDR_WIDTH'(len_reg);
        end
        default: ;
      endcase
    end
  end

  assign pc                    = pc_reg;
  assign bus.mem_re            = mem_re;
  assign bus.mem_addr          = mem_re ? pc_reg + ADDR_WIDTH'(byte_idx_reg) : '0;
  assign bus.instruction_out   = instr_reg;
  assign bus.operand           = operand_reg;
  assign bus.addr_out          = addr_reg;
  assign bus.illegal           = illegal_reg;
  assign bus.instruction_ready = ready;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit: one instance at MEM_LATENCY=1 carries most
// of the sequence, a second at MEM_LATENCY=3 checks the latency scaling.
// Ready latency is measured from the ISSUE cycle of the opcode and equals
// bytes * (MEM_LATENCY + 2): ISSUE, MEM_LATENCY WAIT cycles, CAPTURE per byte.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        pc_load, pc_load3;
  logic [15:0] pc_load_value, pc_load_value3;
  logic [15:0] pc1, pc3;

  int checks = 0;
  int errors = 0;
  int n;

  logic [7:0]  mem [0:65535];
  logic [7:0]  p1_3, p2_3;
  logic [15:0] re_log [$];

  fetch_unit_if bus1 ();
  fetch_unit_if bus3 ();

  fetch_unit #(.MEM_LATENCY(1)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .pc            (pc1),
    .bus           (bus1)
  );

  fetch_unit #(.MEM_LATENCY(3)) u_dut3 (
    .clk           (clk),
    .reset         (reset),
    .pc_load       (pc_load3),
    .pc_load_value (pc_load_value3),
    .pc            (pc3),
    .bus           (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: data valid 1 (resp. 3) cycles after the read strobe.
  always @(posedge clk) begin
    bus1.mem_rdata <= (bus1.mem_re === 1'b1) ? mem[bus1.mem_addr] : 8'h00;
    p1_3           <= (bus3.mem_re === 1'b1) ? mem[bus3.mem_addr] : 8'h00;
    p2_3           <= p1_3;
    bus3.mem_rdata <= p2_3;
  end

  // Addresses of every read strobe on the latency-1 instance.
  always @(posedge clk) begin
    if (bus1.mem_re === 1'b1) re_log.push_back(bus1.mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] re_at(input int i);
    if (i < re_log.size()) return {16'h0000, re_log[i]};
    return 32'hDEAD_BEEF;
  endfunction

  // Waits (negedge-sampled) for ready; n = cycles waited, capped at budget.
  task automatic wait_ready(input bit which, input int budget, output int cnt);
    cnt = 0;
    while (((which == 1'b0) ? bus1.instruction_ready : bus3.instruction_ready) !== 1'b1
           && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic pulse_done();
    bus1.instruction_done = 1'b1;
    @(negedge clk);
    bus1.instruction_done = 1'b0;
  endtask

  task automatic load1(input logic [15:0] addr);
    pc_load       = 1'b1;
    pc_load_value = addr;
    @(negedge clk);
    pc_load       = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    pc_load        = 1'b0;
    pc_load_value  = 16'h0000;
    pc_load3       = 1'b0;
    pc_load_value3 = 16'h0000;
    bus1.instruction_done = 1'b0;
    bus3.instruction_done = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h02;
    mem[16'h8005] = 8'h03;
    mem[16'h8006] = 8'hEA;
    mem[16'h9000] = 8'hEA;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(bus1.instruction_ready), 32'h0);
    chk("rst_mem_re",  32'(bus1.mem_re),            32'h0);
    chk("rst_mem_addr",32'(bus1.mem_addr),          32'h0);
    chk("rst_pc",      32'(pc1),                    32'h0);
    chk("rst_instr",   32'(bus1.instruction_out),   32'h0);
    chk("rst_operand", 32'(bus1.operand),           32'h0);
    chk("rst_addr_out",32'(bus1.addr_out),          32'h0);
    chk("rst_illegal", 32'(bus1.illegal),           32'h0);
    chk("rst3_ready",  32'(bus3.instruction_ready), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_re",  32'(bus1.mem_re),            32'h0);
    $display("reset: checked idle outputs");

    // Load 0x8000, 2-byte A9 42
    re_log.delete();
    load1(16'h8000);
    chk("ld_re",       32'(bus1.mem_re),   32'h1);
    chk("ld_addr",     32'(bus1.mem_addr), 32'h8000);
    wait_ready(1'b0, 40, n);
    chk("lat_2byte",   32'(n),                      32'd6);
    chk("a9_instr",    32'(bus1.instruction_out),   32'hA9);
    chk("a9_operand",  32'(bus1.operand),           32'h0042);
    chk("a9_addr_out", 32'(bus1.addr_out),          32'h8000);
    chk("a9_illegal",  32'(bus1.illegal),           32'h0);
    chk("a9_pc",       32'(pc1),                    32'h8000);
    chk("a9_re_cnt",   32'(re_log.size()),          32'd2);
    chk("a9_re0",      re_at(0),                    32'h8000);
    chk("a9_re1",      re_at(1),                    32'h8001);
    $display("load 8000: A9 operand=%04h latency=%0d", bus1.operand, n);

    // Hold with done low: ready and outputs stable, no reads
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_ready",   32'(bus1.instruction_ready), 32'h1);
      chk("hold_instr",   32'(bus1.instruction_out),   32'hA9);
      chk("hold_operand", 32'(bus1.operand),           32'h0042);
      chk("hold_addr",    32'(bus1.addr_out),          32'h8000);
      chk("hold_re",      32'(bus1.mem_re),            32'h0);
    end
    $display("hold: 10 cycles with done low");

    // Done -> one GAP cycle, then the next fetch at 0x8002
    pulse_done();
    chk("gap_ready",   32'(bus1.instruction_ready), 32'h0);
    chk("gap_re",      32'(bus1.mem_re),            32'h0);
    chk("gap_pc",      32'(pc1),                    32'h8002);
    re_log.delete();
    @(negedge clk);
    chk("next_re",     32'(bus1.mem_re),            32'h1);
    chk("next_addr",   32'(bus1.mem_addr),          32'h8002);
    chk("next_ready",  32'(bus1.instruction_ready), 32'h0);
    $display("done: gap then fetch at %04h", bus1.mem_addr);

    // 3-byte 8D 00 02
    wait_ready(1'b0, 40, n);
    chk("lat_3byte",   32'(n),                      32'd9);
    chk("8d_instr",    32'(bus1.instruction_out),   32'h8D);
    chk("8d_operand",  32'(bus1.operand),           32'h0200);
    chk("8d_addr_out", 32'(bus1.addr_out),          32'h8002);
    chk("8d_re_cnt",   32'(re_log.size()),          32'd3);
    chk("8d_re0",      re_at(0),                    32'h8002);
    chk("8d_re1",      re_at(1),                    32'h8003);
    chk("8d_re2",      re_at(2),                    32'h8004);
    pulse_done();
    chk("8d_pc",       32'(pc1),                    32'h8005);
    $display("fetch 8002: 8D operand=%04h pc=%04h", bus1.operand, pc1);

    // Illegal opcode 0x03, length 1
    @(negedge clk);
    wait_ready(1'b0, 40, n);
    chk("lat_1byte",   32'(n),                      32'd3);
    chk("03_instr",    32'(bus1.instruction_out),   32'h03);
    chk("03_illegal",  32'(bus1.illegal),           32'h1);
    chk("03_operand",  32'(bus1.operand),           32'h0000);
    pulse_done();
    chk("03_pc",       32'(pc1),                    32'h8006);
    $display("fetch 8005: 03 illegal=%0d pc=%04h", bus1.illegal, pc1);

    // EA at 0x8006, then pc_load together with done
    @(negedge clk);
    wait_ready(1'b0, 40, n);
    chk("ea_instr",    32'(bus1.instruction_out),   32'hEA);
    chk("ea_illegal",  32'(bus1.illegal),           32'h0);
    pc_load       = 1'b1;
    pc_load_value = 16'h8002;
    bus1.instruction_done = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    bus1.instruction_done = 1'b0;
    chk("ldd_pc",      32'(pc1),                    32'h8002);
    chk("ldd_ready",   32'(bus1.instruction_ready), 32'h0);
    chk("ldd_re",      32'(bus1.mem_re),            32'h1);
    chk("ldd_addr",    32'(bus1.mem_addr),          32'h8002);
    $display("load+done: pc=%04h", pc1);

    // Abort 8D during its operand WAIT with pc_load 0x9000
    repeat (3) @(negedge clk);
    chk("ab_op_addr",  32'(bus1.mem_addr),          32'h8003);
    @(negedge clk);
    chk("ab_wait_re",  32'(bus1.mem_re),            32'h0);
    load1(16'h9000);
    chk("ab_re",       32'(bus1.mem_re),            32'h1);
    chk("ab_addr",     32'(bus1.mem_addr),          32'h9000);
    chk("ab_ready",    32'(bus1.instruction_ready), 32'h0);
    wait_ready(1'b0, 40, n);
    chk("ab_lat",      32'(n),                      32'd3);
    chk("ab_instr",    32'(bus1.instruction_out),   32'hEA);
    chk("ab_addr_out", 32'(bus1.addr_out),          32'h9000);
    $display("abort: restarted at 9000 instr=%02h", bus1.instruction_out);

    // Wrap: 3-byte AD 34 12 at 0xFFFE
    mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    re_log.delete();
    load1(16'hFFFE);
    wait_ready(1'b0, 40, n);
    chk("wr3_lat",     32'(n),                      32'd9);
    chk("wr3_instr",   32'(bus1.instruction_out),   32'hAD);
    chk("wr3_operand", 32'(bus1.operand),           32'h1234);
    chk("wr3_addr_out",32'(bus1.addr_out),          32'hFFFE);
    chk("wr3_re0",     re_at(0),                    32'hFFFE);
    chk("wr3_re1",     re_at(1),                    32'hFFFF);
    chk("wr3_re2",     re_at(2),                    32'h0000);
    pulse_done();
    chk("wr3_pc",      32'(pc1),                    32'h0001);
    $display("wrap FFFE: AD operand=%04h pc=%04h", bus1.operand, pc1);

    // Wrap: 1-byte EA at 0xFFFF
    mem[16'hFFFF] = 8'hEA;
    load1(16'hFFFF);
    wait_ready(1'b0, 40, n);
    chk("wr1_instr",   32'(bus1.instruction_out),   32'hEA);
    chk("wr1_operand", 32'(bus1.operand),           32'h0000);
    chk("wr1_addr_out",32'(bus1.addr_out),          32'hFFFF);
    pulse_done();
    chk("wr1_pc",      32'(pc1),                    32'h0000);
    $display("wrap FFFF: EA pc=%04h", pc1);

    // MEM_LATENCY=3, 2-byte A9 42: 2 * (3 + 2) = 10 cycles
    pc_load3       = 1'b1;
    pc_load_value3 = 16'h8000;
    @(negedge clk);
    pc_load3 = 1'b0;
    chk("l3_re",       32'(bus3.mem_re),            32'h1);
    chk("l3_addr",     32'(bus3.mem_addr),          32'h8000);
    wait_ready(1'b1, 60, n);
    chk("l3_lat",      32'(n),                      32'd10);
    chk("l3_instr",    32'(bus3.instruction_out),   32'hA9);
    chk("l3_operand",  32'(bus3.operand),           32'h0042);
    chk("l3_addr_out", 32'(bus3.addr_out),          32'h8000);
    $display("latency3: A9 ready after %0d cycles", n);

    // Reset mid-fetch
    load1(16'h8002);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_ready",    32'(bus1.instruction_ready), 32'h0);
    chk("mr_re",       32'(bus1.mem_re),            32'h0);
    chk("mr_mem_addr", 32'(bus1.mem_addr),          32'h0);
    chk("mr_pc",       32'(pc1),                    32'h0);
    chk("mr_instr",    32'(bus1.instruction_out),   32'h0);
    chk("mr_operand",  32'(bus1.operand),           32'h0);
    chk("mr_addr_out", 32'(bus1.addr_out),          32'h0);
    chk("mr_illegal",  32'(bus1.illegal),           32'h0);
    chk("mr3_ready",   32'(bus3.instruction_ready), 32'h0);
    reset = 1'b0;
    $display("reset mid-fetch: outputs cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
